// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a 4-bit ALU with a fixed-length execute phase.
// One operation is in flight at a time; the result is held until the consumer takes it.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_out,
    output logic       rsp_cf,
    output logic       rsp_of,
    output logic       rsp_zf
);

    // state | meaning
    // IDLE  | waiting for a request, ready driven to the granted requester
    // EXEC  | counting down the execute phase, then one cycle to publish the result
    // RESP  | result held on rsp_* until the consumer takes it
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_q, state_d;
    logic       rptr_q, rptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [2:0] sel_q, sel_d;
    logic       id_q, id_d;
    logic       rsp_id_q, rsp_id_d;
    logic [3:0] rsp_out_q, rsp_out_d;
    logic       rsp_cf_q, rsp_cf_d, rsp_of_q, rsp_of_d, rsp_zf_q, rsp_zf_d;

    logic       gnt0, gnt1;
    logic [4:0] sum;
    logic [3:0] alu_out;
    logic       alu_cf, alu_of;

    always_comb begin
        sum     = '0;
        alu_out = '0;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
        case (sel_q)
            3'b000: begin
                sum     = {1'b0, a_q} + {1'b0, b_q};
                alu_out = sum[3:0];
                alu_cf  = sum[4];
                alu_of  = (a_q[3] == b_q[3]) && (sum[3] != a_q[3]);
            end
            3'b001: begin
                // no carry out of a + ~b + 1 means a borrow occurred
                sum     = {1'b0, a_q} + {1'b0, ~b_q} + 5'd1;
                alu_out = sum[3:0];
                alu_cf  = ~sum[4];
                alu_of  = (a_q[3] != b_q[3]) && (sum[3] != a_q[3]);
            end
            3'b010: alu_out = ~a_q;
            3'b011: alu_out = a_q & b_q;
            3'b100: alu_out = a_q | b_q;
            3'b101: alu_out = a_q ^ b_q;
            3'b110: alu_out = {3'b000, ($signed(a_q) < $signed(b_q))};
            default: alu_out = {3'b000, (a_q == b_q)};
        endcase
    end

    assign gnt0 = req0_valid && (!req1_valid || !rptr_q);
    assign gnt1 = req1_valid && (!req0_valid || rptr_q);

    assign req0_ready = (state_q == IDLE) && !rst && gnt0;
    assign req1_ready = (state_q == IDLE) && !rst && gnt1;

    always_comb begin
        state_d   = state_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        id_d      = id_q;
        rsp_id_d  = rsp_id_q;
        rsp_out_d = rsp_out_q;
        rsp_cf_d  = rsp_cf_q;
        rsp_of_d  = rsp_of_q;
        rsp_zf_d  = rsp_zf_q;
        case (state_q)
            IDLE: begin
                if (req0_valid && req0_ready) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    sel_d   = req0_sel;
                    id_d    = 1'b0;
                    rptr_d  = 1'b1;
                    cnt_d   = 4'(EXEC_CYCLES - 1);
                    done_d  = 1'b0;
                    state_d = EXEC;
                end else if (req1_valid && req1_ready) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    sel_d   = req1_sel;
                    id_d    = 1'b1;
                    rptr_d  = 1'b0;
                    cnt_d   = 4'(EXEC_CYCLES - 1);
                    done_d  = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (done_q) begin
                    done_d  = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == 4'd0) begin
                    rsp_id_d  = id_q;
                    rsp_out_d = alu_out;
                    rsp_cf_d  = alu_cf;
                    rsp_of_d  = alu_of;
                    rsp_zf_d  = (alu_out == 4'd0);
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rptr_q    <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            id_q      <= 1'b0;
            rsp_id_q  <= 1'b0;
            rsp_out_q <= '0;
            rsp_cf_q  <= 1'b0;
            rsp_of_q  <= 1'b0;
            rsp_zf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            id_q      <= id_d;
            rsp_id_q  <= rsp_id_d;
            rsp_out_q <= rsp_out_d;
            rsp_cf_q  <= rsp_cf_d;
            rsp_of_q  <= rsp_of_d;
            rsp_zf_q  <= rsp_zf_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_cf    = rsp_cf_q;
    assign rsp_of    = rsp_of_q;
    assign rsp_zf    = rsp_zf_q;

endmodule
